// File: rtl/scan_link_arbiter.sv
`timescale 1ns/1ps
// scan_link_arbiter: round-robin sharing of one serial link between two scanners.
// Optional WAIT-state watchdog is built when SCAN_LINK_WATCHDOG_EN is defined.
module scan_link_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       done,
    output logic [1:0]       grant,
    output logic             owner,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count,
    output logic             timeout_err,
    output logic [1:0]       ps
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        WAIT    = 2'b10,
        RELEASE = 2'b11
    } state_t;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [GAP_W-1:0] gapCnt;
    logic             winner;
    logic             wdExpire;

    assign ps = state;

    // Single requester wins outright; on contention the non-owner wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10)
            winner = 1'b1;
        else if (req == 2'b11)
            winner = ~owner;
    end

`ifdef SCAN_LINK_WATCHDOG_EN
    localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdCnt;
    logic            timeoutQ;

    assign wdExpire    = (wdCnt == WD_LAST);
    assign timeout_err = timeoutQ;

    // Cleared while in GRANT so it starts from zero on the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt    <= '0;
            timeoutQ <= 1'b0;
        end else begin
            timeoutQ <= (state == WAIT) && !done[owner] && wdExpire;
            if (state == GRANT)
                wdCnt <= '0;
            else if (state == WAIT)
                wdCnt <= wdCnt + 1'b1;
        end
    end
`else
    assign wdExpire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= 1'b1;
            busy       <= 1'b0;
            xfer_count <= '0;
            gapCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state <= GRANT;
                        busy  <= 1'b1;
                        owner <= winner;
                        grant <= winner ? 2'b10 : 2'b01;
                    end
                end
                GRANT: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // done beats a coincident watchdog expiry
                    if (done[owner]) begin
                        state      <= RELEASE;
                        grant      <= '0;
                        gapCnt     <= '0;
                        xfer_count <= xfer_count + 1'b1;
                    end else if (wdExpire) begin
                        state  <= RELEASE;
                        grant  <= '0;
                        gapCnt <= '0;
                    end
                end
                RELEASE: begin
                    if (gapCnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_link_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for scan_link_arbiter: transaction-level model predicts grant and
// release edges; a negedge monitor pops and compares whenever grant rises or falls.
module tb_scan_link_arbiter;

    localparam int GAP = 2;
    localparam int TMO = 64;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [1:0]    done = 2'b00;
    logic [1:0]    grant;
    logic          owner;
    logic          busy;
    logic [CW-1:0] xfer_count;
    logic          timeout_err;
    logic [1:0]    ps;

    always #5 clk = ~clk;

    scan_link_arbiter #(
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .grant(grant),
        .owner(owner),
        .busy(busy),
        .xfer_count(xfer_count),
        .timeout_err(timeout_err),
        .ps(ps)
    );

    typedef struct {
        bit            isEnd;
        int            edgeAt;
        logic [1:0]    gnt;
        logic          own;
        logic [CW-1:0] cnt;
        logic          te;
    } exp_t;

    exp_t sb[$];
    exp_t monE;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          cyc   = 0;
    int          idleCheckAt = -1;
    bit          tePend = 1'b0;
    logic [1:0]  prevG = 2'b00;

    // Reference model state: last winner, edge of last release, completed count.
    logic lastOwn  = 1'b1;
    int   lastDone = -100;
    int   expCnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prevG       = 2'b00;
            idleCheckAt = -1;
            tePend      = 1'b0;
        end else begin
            if (tePend) begin
                check("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);
                tePend = 1'b0;
            end
            if (cyc == idleCheckAt) begin
                check("idle_ps", {30'd0, ps}, 32'd0);
                check("idle_busy", {31'd0, busy}, 32'd0);
                idleCheckAt = -1;
            end
            if (prevG == 2'b00 && grant != 2'b00) begin
                if (sb.size() == 0 || sb[0].isEnd) begin
                    check("unexpected_grant", {30'd0, grant}, 32'd0);
                end else begin
                    monE = sb.pop_front();
                    check("grant_value", {30'd0, grant}, {30'd0, monE.gnt});
                    check("grant_owner", {31'd0, owner}, {31'd0, monE.own});
                    check("grant_cycle", cyc, monE.edgeAt);
                    check("grant_ps", {30'd0, ps}, 32'd1);
                    check("grant_busy", {31'd0, busy}, 32'd1);
                end
            end else if (prevG != 2'b00 && grant == 2'b00) begin
                if (sb.size() == 0 || !sb[0].isEnd) begin
                    check("unexpected_release", {30'd0, grant}, {30'd0, prevG});
                end else begin
                    monE = sb.pop_front();
                    check("release_cycle", cyc, monE.edgeAt);
                    check("release_count", {{(32-CW){1'b0}}, xfer_count}, {{(32-CW){1'b0}}, monE.cnt});
                    check("release_timeout", {31'd0, timeout_err}, {31'd0, monE.te});
                    check("release_ps", {30'd0, ps}, 32'd3);
                    idleCheckAt = cyc + GAP;
                    tePend      = monE.te;
                end
            end else if (grant != prevG) begin
                check("grant_stable", {30'd0, grant}, {30'd0, prevG});
            end
            prevG = grant;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives a request pattern and predicts which scanner wins and on which edge.
    task automatic arbitrate(input logic [1:0] pat, input int unsigned idleK, output logic w, output int g);
        int   reqEdge;
        exp_t e;
        if (idleK > 0) begin
            req = 2'b00;
            repeat (idleK) nextCycle();
        end
        req     = pat;
        reqEdge = cyc + 1;
        w = (pat == 2'b10) ? 1'b1 : (pat == 2'b01) ? 1'b0 : ~lastOwn;
        g = (reqEdge > lastDone + GAP + 1) ? reqEdge : lastDone + GAP + 1;
        e.isEnd = 1'b0; e.edgeAt = g; e.gnt = w ? 2'b10 : 2'b01;
        e.own = w; e.cnt = '0; e.te = 1'b0;
        sb.push_back(e);
        lastOwn = w;
        while (cyc < g) nextCycle();
    endtask

    task automatic xfer(input logic [1:0] pat, input int unsigned idleK, input int unsigned waitW,
                        input bit staleDone, input bit noise, input bit dropReq);
        logic w;
        int   g;
        int   d;
        exp_t e;
        arbitrate(pat, idleK, w, g);
        if (staleDone) done = w ? 2'b10 : 2'b01;
        nextCycle();
        check("wait_ps", {30'd0, ps}, 32'd2);
        done = noise ? (w ? 2'b01 : 2'b10) : 2'b00;
        if (dropReq) req = pat & (w ? 2'b01 : 2'b10);
        repeat (waitW) nextCycle();
        d      = cyc + 1;
        expCnt = (expCnt + 1) % (1 << CW);
        e.isEnd = 1'b1; e.edgeAt = d; e.gnt = 2'b00; e.own = w;
        e.cnt = CW'(expCnt); e.te = 1'b0;
        sb.push_back(e);
        done = (w ? 2'b10 : 2'b01) | (noise ? (w ? 2'b01 : 2'b10) : 2'b00);
        nextCycle();
        done     = 2'b00;
        lastDone = d;
    endtask

    task automatic randomXfer();
        logic [1:0]  pat;
        int unsigned idleK;
        pat   = 2'($urandom_range(1, 3));
        idleK = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        xfer(pat, idleK, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic resetMidWait();
        logic w;
        int   g;
        arbitrate(2'b11, 0, w, g);
        nextCycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_grant", {30'd0, grant}, 32'd0);
        check("arst_ps", {30'd0, ps}, 32'd0);
        check("arst_count", {{(32-CW){1'b0}}, xfer_count}, 32'd0);
        check("arst_owner", {31'd0, owner}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        req = 2'b11;
        lastOwn  = 1'b1;
        lastDone = -100;
        expCnt   = 0;
        nextCycle();
        rst = 1'b0;
    endtask

`ifdef SCAN_LINK_WATCHDOG_EN
    task automatic watchdogCase();
        logic w;
        int   g;
        int   t;
        exp_t e;
        arbitrate(2'b01, 0, w, g);
        t = g + 1 + TMO;
        e.isEnd = 1'b1; e.edgeAt = t; e.gnt = 2'b00; e.own = w;
        e.cnt = CW'(expCnt); e.te = 1'b1;
        sb.push_back(e);
        while (cyc < t) nextCycle();
        lastDone = t;
        xfer(2'b11, 0, 1, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", {30'd0, grant}, 32'd0);
        check("reset_ps", {30'd0, ps}, 32'd0);
        check("reset_owner", {31'd0, owner}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_count", {{(32-CW){1'b0}}, xfer_count}, 32'd0);
        check("reset_timeout", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        nextCycle();

        xfer(2'b01, 0, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) xfer(2'b11, 0, $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
        xfer(2'b11, 0, 3, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) randomXfer();

        resetMidWait();
        for (int i = 0; i < 270; i++) randomXfer();

`ifdef SCAN_LINK_WATCHDOG_EN
        watchdogCase();
`endif

        req = 2'b00;
        repeat (GAP + 4) nextCycle();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
